data_memory_loader: RTL

DATA_MEMORY_LOADER -- requirements
Module: data_memory_loader

---
 rtl/processor_pkg.sv | 17 +
 rtl/data_memory_loader.sv | 122 ++++++++++++
 2 files changed

// File: rtl/processor_pkg.sv
// Shared processor-side types and constants: loader FSM encoding and load image sizing.
package processor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_LO,
    HDR_HI,
    LOAD,
    RELEASE,
    DONE
  } loader_state_t;

  localparam int unsigned LOADER_CAPACITY = 512;
  localparam int unsigned LOADER_LEN_W    = 16;
  localparam int unsigned LOADER_CNT_W    = 17;

endpackage

// File: rtl/data_memory_loader.sv
// Streams a length-prefixed byte image into the two interleaved data memory banks
// while holding the processor in reset, then releases it.
module data_memory_loader
  import processor_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned CAPACITY   = LOADER_CAPACITY
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_write_even,
  output logic                  mem_write_odd,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [7:0]            mem_data,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int unsigned LenW = LOADER_LEN_W;
  localparam int unsigned CntW = LOADER_CNT_W;

  loader_state_t   state;
  loader_state_t   stateNext;
  logic [LenW-1:0] length;
  logic [CntW-1:0] count;
  logic [LenW-1:0] hdrLength;
  logic            lastByte;
  logic            inCapacity;
  logic            sessionStart;

  assign hdrLength    = {rx_data, length[7:0]};
  assign lastByte     = (count + CntW'(1)) == CntW'(length);
  assign inCapacity   = count < CntW'(CAPACITY);
  assign sessionStart = start && ((state == IDLE) || (state == DONE));

  // Next-state decode; rx_ready is the only unregistered output.
  always_comb begin
    stateNext = state;
    rx_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (start) stateNext = HDR_LO;
      end
      HDR_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) stateNext = HDR_HI;
      end
      HDR_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) stateNext = (hdrLength == '0) ? RELEASE : LOAD;
      end
      LOAD: begin
        rx_ready = 1'b1;
        if (rx_valid && lastByte) stateNext = RELEASE;
      end
      RELEASE: begin
        stateNext = DONE;
      end
      DONE: begin
        if (start) stateNext = HDR_LO;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      length         <= '0;
      count          <= '0;
      cpu_reset      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      overflow       <= 1'b0;
      mem_write_even <= 1'b0;
      mem_write_odd  <= 1'b0;
      mem_address    <= '0;
      mem_data       <= '0;
    end else begin
      state          <= stateNext;
      // Status follows the next state so a reload reasserts cpu_reset on the start edge.
      cpu_reset      <= (stateNext != DONE);
      busy           <= (stateNext == HDR_LO) || (stateNext == HDR_HI) ||
                        (stateNext == LOAD)   || (stateNext == RELEASE);
      done           <= (stateNext == DONE);
      mem_write_even <= 1'b0;
      mem_write_odd  <= 1'b0;

      if (sessionStart) begin
        count  <= '0;
        length <= '0;
      end

      if ((state == HDR_LO) && rx_valid) length[7:0] <= rx_data;

      if ((state == HDR_HI) && rx_valid) begin
        length[15:8] <= rx_data;
        if (CntW'(hdrLength) > CntW'(CAPACITY)) overflow <= 1'b1;
      end

      // Bytes beyond the banks are consumed but never written.
      if ((state == LOAD) && rx_valid) begin
        count <= count + CntW'(1);
        if (inCapacity) begin
          mem_write_even <= ~count[0];
          mem_write_odd  <= count[0];
          mem_address    <= count[ADDR_WIDTH:1];
          mem_data       <= rx_data;
        end
      end
    end
  end

endmodule
